// File: rtl/blink_pkg.sv
// Shared types and helpers for the blink generator monitor.
package blink_pkg;

  // Monitor lock state
  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOCKED,
    FAULT
  } state_t;

  // Cause reported alongside the sticky error
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_EARLY,
    ERR_MISSING,
    ERR_TOGGLE
  } err_code_t;

  // Gap value seen on the cycle a correctly spaced flag arrives: D-1 = 2^cbits - 1
  function automatic int unsigned gap_limit(input int unsigned cbits);
    return (32'd1 << cbits) - 32'd1;
  endfunction

endpackage

// File: rtl/blink_gap_ctr.sv
// Saturating cycles-since-last-flag counter for blink_monitor.
// o_gap clears on i_clear and otherwise counts up, sticking at all-ones.
module blink_gap_ctr
  import blink_pkg::*;
#(
  parameter int CBITS = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clear,
  output logic [CBITS:0] o_gap,
  output logic           o_at_limit
);

  localparam int             W        = CBITS + 1;
  localparam logic [CBITS:0] LP_LIMIT = W'(gap_limit(CBITS));

  logic [CBITS:0] r_gap;

  // Count cycles since the last flag; never wrap past all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_gap <= '0;
    end else if (i_clear) begin
      r_gap <= '0;
    end else if (r_gap != '1) begin
      r_gap <= r_gap + W'(1);
    end
  end

  assign o_gap      = r_gap;
  assign o_at_limit = (r_gap == LP_LIMIT);

endmodule

// File: rtl/blink_monitor.sv
// Lock/check monitor for the blink generator's led/flg pair.
// Locks onto flg pulses spaced 2^CBITS cycles apart, then flags EARLY,
// MISSING and (optionally) TOGGLE violations with a sticky error.
// Build option: BLINK_MON_TOGGLE_CHECK_EN enables the led toggle checks;
// without it led is ignored and err_code never reports ERR_TOGGLE.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int CBITS = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           led,
  input  logic           flg,
  input  logic           clr,
  output logic           locked,
  output logic           err,
  output logic [1:0]     err_code,
  output logic [CBITS:0] period
);

  localparam int             W        = CBITS + 1;
  localparam logic [CBITS:0] LP_LIMIT = W'(gap_limit(CBITS));

  state_t         r_state;
  state_t         w_state_nxt;
  err_code_t      r_err_code;
  err_code_t      w_code_nxt;
  logic           r_locked;
  logic           r_err;
  logic [CBITS:0] r_period;
  logic [CBITS:0] w_period_nxt;
  logic           w_period_ld;
  logic [CBITS:0] w_gap;
  logic           w_at_limit;
  logic           w_tog_err;
  logic           w_early;
  logic           w_missing;

  // A clear in the same cycle as flg restarts the gap as well
  blink_gap_ctr #(.CBITS(CBITS)) u_gap_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (flg | clr),
    .o_gap     (w_gap),
    .o_at_limit(w_at_limit)
  );

`ifdef BLINK_MON_TOGGLE_CHECK_EN
  logic r_led_q;
  logic r_flg_q;

  // Previous-cycle samples for toggle detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_q <= 1'b0;
      r_flg_q <= 1'b0;
    end else begin
      r_led_q <= led;
      r_flg_q <= flg;
    end
  end

  // led must toggle exactly on the cycle after a flag: toggle != flg_q is an error
  assign w_tog_err = (led ^ r_led_q) ^ r_flg_q;
`else
  logic w_unused_led;
  assign w_unused_led = led;
  assign w_tog_err    = 1'b0;
`endif

  assign w_early   = flg & (w_gap < LP_LIMIT);
  assign w_missing = ~flg & w_at_limit;

  // Measured distance is gap+1, held at all-ones once the gap saturates
  assign w_period_nxt = (&w_gap) ? w_gap : w_gap + W'(1);

  // Next-state, error-code and period-load decode
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_code_nxt  = r_err_code;
    w_period_ld = 1'b0;
    if (clr) begin
      w_state_nxt = IDLE;
      w_code_nxt  = ERR_NONE;
    end else begin
      w_period_ld = flg && (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          if (flg) w_state_nxt = SYNC;
        end
        SYNC: begin
          if (flg && w_at_limit) w_state_nxt = LOCKED;
        end
        LOCKED: begin
          if (w_tog_err) begin
            w_state_nxt = FAULT;
            w_code_nxt  = ERR_TOGGLE;
          end else if (w_early) begin
            w_state_nxt = FAULT;
            w_code_nxt  = ERR_EARLY;
          end else if (w_missing) begin
            w_state_nxt = FAULT;
            w_code_nxt  = ERR_MISSING;
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_err_code <= ERR_NONE;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_period   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_err_code <= w_code_nxt;
      r_locked   <= (w_state_nxt == LOCKED);
      r_err      <= (w_state_nxt == FAULT);
      if (w_period_ld) r_period <= w_period_nxt;
    end
  end

  assign locked   = r_locked;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign period   = r_period;

endmodule

// File: tb/tb_blink_monitor.sv
// Self-checking bench for blink_monitor at CBITS=4 (D=16).
// Directed scenario table, hand-written corner sequences and a randomized
// run against a cycle-distance reference model.
module tb_blink_monitor;

  localparam int CBITS = 4;
  localparam int D     = 1 << CBITS;
  localparam int SAT   = (1 << (CBITS + 1)) - 1;
`ifdef BLINK_MON_TOGGLE_CHECK_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  localparam int K_NONE  = 0;
  localparam int K_EARLY = 1;
  localparam int K_MISS  = 2;
  localparam int K_TOG   = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           led = 1'b0;
  logic           flg = 1'b0;
  logic           clr = 1'b0;
  logic           locked;
  logic           err;
  logic [1:0]     err_code;
  logic [CBITS:0] period;

  int n_pass = 0;
  int n_total = 0;

  blink_monitor #(.CBITS(CBITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .led     (led),
    .flg     (flg),
    .clr     (clr),
    .locked  (locked),
    .err     (err),
    .err_code(err_code),
    .period  (period)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int m_since;
  bit m_prev_led, m_prev_flg;
  bit m_seen, m_locked, m_fault;
  int m_code, m_period;

  task automatic model_reset();
    m_since = 0; m_prev_led = 0; m_prev_flg = 0;
    m_seen = 0; m_locked = 0; m_fault = 0; m_code = 0; m_period = 0;
  endtask

  task automatic model_step(input bit l, input bit f, input bit c);
    int g;
    bit bad_tog;
    g = (m_since > SAT) ? SAT : m_since;
    if (c) begin
      m_seen = 0; m_locked = 0; m_fault = 0; m_code = 0;
    end else begin
      if (f && (m_seen || m_locked || m_fault))
        m_period = (g + 1 > SAT) ? SAT : g + 1;
      if (m_fault) begin
        // sticky until clear
      end else if (m_locked) begin
        bad_tog = TOG_EN && ((l != m_prev_led) != m_prev_flg);
        if (bad_tog)                begin m_fault = 1; m_code = 3; end
        else if (f && g < D - 1)    begin m_fault = 1; m_code = 1; end
        else if (!f && g == D - 1)  begin m_fault = 1; m_code = 2; end
      end else if (m_seen) begin
        if (f && g == D - 1) m_locked = 1;
      end else if (f) begin
        m_seen = 1;
      end
    end
    m_since = (f || c) ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
    m_prev_led = l;
    m_prev_flg = f;
  endtask

  // ---------------- generator emulation ----------------
  int gen_cnt;
  bit gen_led, gen_prev_flg;

  task automatic gen_reset();
    gen_cnt = 0; gen_led = 0; gen_prev_flg = 0;
  endtask

  // One clock of a healthy generator with optional faults; compares against the model
  task automatic gen_cycle(input bit force_flg, input bit kill_flg,
                           input bit flip_led, input bit do_clr);
    bit f;
    f = (gen_cnt == D - 1);
    if (force_flg) f = 1'b1;
    if (kill_flg)  f = 1'b0;
    gen_led = gen_led ^ gen_prev_flg ^ flip_led;
    led = gen_led; flg = f; clr = do_clr;
    @(posedge clk);
    #1;
    model_step(gen_led, f, do_clr);
    gen_prev_flg = f;
    gen_cnt = (gen_cnt + 1) % D;
    check("model_locked", {31'd0, locked}, {31'd0, m_locked && !m_fault});
    check("model_err",    {31'd0, err},    {31'd0, m_fault});
    check("model_code",   {30'd0, err_code}, m_code);
    check("model_period", {27'd0, period}, m_period);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; led = 1'b0; flg = 1'b0; clr = 1'b0;
    #1;
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_err",    {31'd0, err}, 0);
    check("rst_code",   {30'd0, err_code}, 0);
    check("rst_period", {27'd0, period}, 0);
    model_reset();
    gen_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int offset;     // healthy cycles after lock before the perturbed cycle
    int kind;
    bit e_locked;
    bit e_err;
    int e_code;
    int e_period;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{9,  K_EARLY, 1'b0, 1'b1, 1, 10};
    vecs[1] = '{15, K_MISS,  1'b0, 1'b1, 2, 16};
`ifdef BLINK_MON_TOGGLE_CHECK_EN
    vecs[2] = '{5,  K_TOG,   1'b0, 1'b1, 3, 16};
`else
    vecs[2] = '{5,  K_TOG,   1'b1, 1'b0, 0, 16};
`endif
    vecs[3] = '{20, K_NONE,  1'b1, 1'b0, 0, 16};
    vecs[4] = '{0,  K_EARLY, 1'b0, 1'b1, 1, 1};
    vecs[5] = '{14, K_EARLY, 1'b0, 1'b1, 1, 15};

    // ---- table-driven scenarios ----
    for (int i = 0; i < 6; i++) begin
      do_reset();
      repeat (2 * D - 1) gen_cycle(0, 0, 0, 0);
      check($sformatf("v%0d_pre_lock", i), {31'd0, locked}, 0);
      gen_cycle(0, 0, 0, 0);
      check($sformatf("v%0d_lock", i), {31'd0, locked}, 1);
      check($sformatf("v%0d_lock_period", i), {27'd0, period}, D);
      repeat (vecs[i].offset) gen_cycle(0, 0, 0, 0);
      case (vecs[i].kind)
        K_EARLY: gen_cycle(1, 0, 0, 0);
        K_MISS:  gen_cycle(0, 1, 0, 0);
        K_TOG:   gen_cycle(0, 0, 1, 0);
        default: gen_cycle(0, 0, 0, 0);
      endcase
      check($sformatf("v%0d_locked", i), {31'd0, locked}, vecs[i].e_locked);
      check($sformatf("v%0d_err", i),    {31'd0, err},    vecs[i].e_err);
      check($sformatf("v%0d_code", i),   {30'd0, err_code}, vecs[i].e_code);
      check($sformatf("v%0d_period", i), {27'd0, period}, vecs[i].e_period);
    end

    // ---- healthy generator for 100 pulses ----
    do_reset();
    repeat (2 * D) gen_cycle(0, 0, 0, 0);
    repeat (100 * D) gen_cycle(0, 0, 0, 0);
    check("healthy_locked", {31'd0, locked}, 1);
    check("healthy_err",    {31'd0, err}, 0);
    check("healthy_period", {27'd0, period}, D);

    // ---- clr coinciding with flg in FAULT, then relock ----
    do_reset();
    repeat (2 * D) gen_cycle(0, 0, 0, 0);
    repeat (9) gen_cycle(0, 0, 0, 0);
    gen_cycle(1, 0, 0, 0);
    check("clr_pre_err", {31'd0, err}, 1);
    for (int i = 0; i < D && gen_cnt != D - 1; i++) gen_cycle(0, 0, 0, 0);
    gen_cycle(0, 0, 0, 1);
    check("clr_err",    {31'd0, err}, 0);
    check("clr_code",   {30'd0, err_code}, 0);
    check("clr_locked", {31'd0, locked}, 0);
    check("clr_period", {27'd0, period}, 10);
    repeat (D) gen_cycle(0, 0, 0, 0);
    check("relock1_locked", {31'd0, locked}, 0);
    check("relock1_period", {27'd0, period}, 10);
    repeat (D) gen_cycle(0, 0, 0, 0);
    check("relock2_locked", {31'd0, locked}, 1);
    check("relock2_period", {27'd0, period}, D);

    // ---- asynchronous reset while locked, then silent generator ----
    do_reset();
    repeat (2 * D + 3) gen_cycle(0, 0, 0, 0);
    check("async_pre_locked", {31'd0, locked}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_locked", {31'd0, locked}, 0);
    check("async_err",    {31'd0, err}, 0);
    check("async_code",   {30'd0, err_code}, 0);
    check("async_period", {27'd0, period}, 0);
    model_reset();
    gen_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) gen_cycle(0, 1, 0, 0);
    check("silent_err",    {31'd0, err}, 0);
    check("silent_locked", {31'd0, locked}, 0);

    // ---- randomized perturbations against the model ----
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 255);
      gen_cycle(r < 3, (r >= 3) && (r < 6), (r >= 6) && (r < 9), r == 9);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
